// File: rtl/mmc_cmd_shifter_pkg.sv
// Shared definitions for the MMC command-line shifter: FSM states, frame lengths, CRC7 step.
package mmc_cmd_shifter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_START,
        RECV,
        TRAIL
    } state_t;

    localparam int unsigned MMC_CMD_LEN       = 48;
    localparam int unsigned MMC_RESP_LONG_LEN = 136;
    localparam logic [6:0]  CRC7_POLY         = 7'h09;

    // One serial CRC7 step (x^7 + x^3 + 1), MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/mmc_cmd_shifter_crc7.sv
// Serial CRC7 accumulator shared by the command TX and response RX paths.
// Only built when MMC_CMD_CRC7_EN is defined.
`ifdef MMC_CMD_CRC7_EN
module mmc_crc7
    import mmc_cmd_shifter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule
`endif

// File: rtl/mmc_cmd_shifter.sv
// MMC CMD-line serialiser/deserialiser paced by the bit-clock generator (tick/bit_ack/bit_done).
// Optional CRC7 generation/checking is enabled by defining MMC_CMD_CRC7_EN.
module mmc_cmd_shifter
    import mmc_cmd_shifter_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter int unsigned NRC_BITS     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [47:0]  cmd_data,
    input  logic         resp_expected,
    input  logic         resp_long,
    output logic         tick,
    input  logic         bit_ack,
    input  logic         bit_done,
    output logic         mmc_cmd_o,
    output logic         mmc_cmd_oe,
    input  logic         mmc_cmd_i,
    output logic [135:0] resp_data,
    output logic         resp_valid,
    output logic         resp_timeout,
    output logic         resp_crc_err,
    output logic         busy
);

    localparam logic [7:0] SEND_LAST   = 8'(MMC_CMD_LEN - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(RESP_TIMEOUT - 1);
    localparam logic [7:0] TRAIL_LAST  = 8'(NRC_BITS - 1);
    localparam logic [7:0] SHORT_LAST  = 8'(MMC_CMD_LEN - 2);
    localparam logic [7:0] LONG_LAST   = 8'(MMC_RESP_LONG_LEN - 2);
    localparam logic [7:0] CRC_LAST_IN = 8'(MMC_CMD_LEN - 9);

    state_t       state, state_nxt;
    logic [7:0]   req_cnt, bit_cnt;
    logic [47:0]  tx_sr, tx_next;
    logic         resp_exp_q, resp_long_q, got_resp;
    logic         handshake, send_last, start_seen, wait_expired, recv_last, trail_last;

    assign handshake    = cmd_valid & cmd_ready;
    assign send_last    = (state == SEND) & bit_done & (bit_cnt == SEND_LAST);
    assign start_seen   = (state == WAIT_START) & bit_done & ~mmc_cmd_i;
    assign wait_expired = (state == WAIT_START) & bit_done & mmc_cmd_i & (bit_cnt == WAIT_LAST);
    assign recv_last    = (state == RECV) & bit_done &
                          (bit_cnt == (resp_long_q ? LONG_LAST : SHORT_LAST));
    assign trail_last   = (state == TRAIL) & bit_done & (bit_cnt == TRAIL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (handshake) state_nxt = SEND;
            SEND:       if (send_last) state_nxt = resp_exp_q ? WAIT_START : TRAIL;
            WAIT_START: begin
                if (start_seen)        state_nxt = RECV;
                else if (wait_expired) state_nxt = TRAIL;
            end
            RECV:       if (recv_last)  state_nxt = TRAIL;
            TRAIL:      if (trail_last) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        tick       = (state != IDLE) && (req_cnt != '0);
        mmc_cmd_oe = (state == SEND);
        mmc_cmd_o  = (state == SEND) ? tx_sr[47] : 1'b1;
    end

`ifdef MMC_CMD_CRC7_EN
    logic [6:0] crc;
    logic       crc_en, crc_din, crc_err_q;

    // Start bit is fed in WAIT_START, so RECV adds only 39 more bits to cover [47:8].
    assign crc_en  = ((state == SEND) & bit_done & (bit_cnt <= CRC_LAST_IN)) | start_seen |
                     ((state == RECV) & bit_done & (bit_cnt < CRC_LAST_IN));
    assign crc_din = (state == SEND) ? tx_sr[47] : mmc_cmd_i;

    mmc_crc7 u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clear  (handshake | send_last),
        .enable (crc_en),
        .din    (crc_din),
        .crc    (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_err_q    <= 1'b0;
            resp_crc_err <= 1'b0;
        end else begin
            resp_crc_err <= 1'b0;
            if (handshake)
                crc_err_q <= 1'b0;
            else if (recv_last)
                crc_err_q <= ~resp_long_q && (crc != resp_data[6:0]);
            if (trail_last)
                resp_crc_err <= resp_exp_q & got_resp & crc_err_q;
        end
    end
`else
    assign resp_crc_err = 1'b0;
`endif

    always_comb begin
        tx_next = {tx_sr[46:0], 1'b1};
`ifdef MMC_CMD_CRC7_EN
        // On the 40th shift the CRC7 field lands at the top, replacing cmd_data[7:1].
        if (bit_cnt == CRC_LAST_IN)
            tx_next[47:41] = crc7_step(crc, tx_sr[47]);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt      <= '0;
            bit_cnt      <= '0;
            tx_sr        <= '0;
            resp_data    <= '0;
            resp_exp_q   <= 1'b0;
            resp_long_q  <= 1'b0;
            got_resp     <= 1'b0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;

            if (state_nxt != state)
                bit_cnt <= '0;
            else if (bit_done && state != IDLE)
                bit_cnt <= bit_cnt + 8'd1;

            if (state_nxt != state) begin
                case (state_nxt)
                    SEND:       req_cnt <= 8'(MMC_CMD_LEN);
                    WAIT_START: req_cnt <= 8'(RESP_TIMEOUT);
                    RECV:       req_cnt <= resp_long_q ? 8'(MMC_RESP_LONG_LEN - 1)
                                                       : 8'(MMC_CMD_LEN - 1);
                    TRAIL:      req_cnt <= 8'(NRC_BITS);
                    default:    req_cnt <= '0;
                endcase
            end else if (bit_ack && tick) begin
                req_cnt <= req_cnt - 8'd1;
            end

            if (handshake) begin
                tx_sr       <= cmd_data;
                resp_exp_q  <= resp_expected;
                resp_long_q <= resp_long;
                got_resp    <= 1'b0;
            end else if (state == SEND && bit_done) begin
                tx_sr <= tx_next;
            end

            if (start_seen) begin
                resp_data <= '0;
                got_resp  <= 1'b1;
            end else if (state == RECV && bit_done) begin
                resp_data <= {resp_data[134:0], mmc_cmd_i};
            end

            if (trail_last) begin
                resp_valid   <= resp_exp_q & got_resp;
                resp_timeout <= resp_exp_q & ~got_resp;
            end
        end
    end

endmodule

// File: tb/tb_mmc_cmd_shifter.sv
// Directed bench for mmc_cmd_shifter with a behavioural bit-clock generator and response driver.
module tb_mmc_cmd_shifter;

    localparam int PER = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [47:0]  cmd_data;
    logic         resp_expected, resp_long;
    logic         tick, bit_ack, bit_done;
    logic         mmc_cmd_o, mmc_cmd_oe, mmc_cmd_i;
    logic [135:0] resp_data;
    logic         resp_valid, resp_timeout, resp_crc_err, busy;

    mmc_cmd_shifter #(.RESP_TIMEOUT(64), .NRC_BITS(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .resp_expected(resp_expected), .resp_long(resp_long),
        .tick(tick), .bit_ack(bit_ack), .bit_done(bit_done),
        .mmc_cmd_o(mmc_cmd_o), .mmc_cmd_oe(mmc_cmd_oe), .mmc_cmd_i(mmc_cmd_i),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_timeout(resp_timeout),
        .resp_crc_err(resp_crc_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0, n_bad = 0;
    int           ph = 0, ack_count = 0, nvalid = 0, ntimeout = 0, ncrc = 0;
    int           valid_at_ack = -1, timeout_at_ack = -1, tick_gaps = 0;
    int           resp_delay = 0, resp_len = 48, mon_end = 0;
    bit           running = 0, cont = 0, start = 0, resp_arm = 0, mon_en = 0;
    logic [47:0]  tx_cap = '0;
    logic [135:0] resp_vec = '0;
    logic [47:0]  r_short = 48'h48000001AA87;
    logic [135:0] r_cid   = 136'h3F_0123456789ABCDEF_FEDCBA9876543211;

    task automatic check_v(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Clock-generator model: ack starts a period, done ends it; tick sampled in the done cycle.
    initial begin
        bit_ack = 1'b0; bit_done = 1'b0; mmc_cmd_i = 1'b1;
        forever begin
            @(negedge clk);
            bit_ack = 1'b0; bit_done = 1'b0;
            if (resp_valid === 1'b1) begin
                nvalid++; valid_at_ack = ack_count;
                if (resp_crc_err === 1'b1) ncrc++;
            end
            if (resp_timeout === 1'b1) begin
                ntimeout++; timeout_at_ack = ack_count;
            end
            if (running && ph < PER - 1) begin
                ph++;
                if (ph == PER - 1) begin
                    bit_done = 1'b1;
                    cont = tick;
                    if (mmc_cmd_oe === 1'b1) tx_cap = {tx_cap[46:0], mmc_cmd_o};
                end
            end else begin
                start = running ? (cont || tick) : tick;
                running = 1'b0;
                if (start) begin
                    running = 1'b1; ph = 0; bit_ack = 1'b1; ack_count++;
                    if (resp_arm && ack_count >= 48 + resp_delay && ack_count < 48 + resp_delay + resp_len)
                        mmc_cmd_i = resp_vec[resp_len - 1 - (ack_count - 48 - resp_delay)];
                    else
                        mmc_cmd_i = 1'b1;
                end
            end
            if (mon_en && ack_count >= 49 && ack_count < mon_end && tick !== 1'b1) tick_gaps++;
        end
    end

    task automatic clear_counts();
        ack_count = 0; tx_cap = '0; nvalid = 0; ntimeout = 0; ncrc = 0; tick_gaps = 0;
        valid_at_ack = -1; timeout_at_ack = -1; resp_arm = 0; mon_en = 0;
    endtask

    task automatic send_cmd(input logic [47:0] d, input logic re, input logic rl);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = d; resp_expected = re; resp_long = rl;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_b(tag, cmd_ready, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; resp_expected = 1'b0; resp_long = 1'b0;
        repeat (3) @(negedge clk);
        check_b("rst_tick", tick, 1'b0);
        check_b("rst_oe", mmc_cmd_oe, 1'b0);
        check_b("rst_cmd_o", mmc_cmd_o, 1'b1);
        check_b("rst_ready", cmd_ready, 1'b1);
        check_b("rst_busy", busy, 1'b0);
        check_v("rst_resp_data", resp_data, '0);
        check_b("rst_pulses", resp_valid | resp_timeout | resp_crc_err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: CMD0, no response; a request while busy must be ignored
        clear_counts();
        send_cmd(48'h400000000095, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 48'hFFFF_FFFF_FFFF; resp_expected = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle("t1_done");
        check_v("t1_tx_bits", {88'b0, tx_cap}, {88'b0, 48'h400000000095});
        check_i("t1_acks", ack_count, 56);
        check_i("t1_pulses", nvalid + ntimeout, 0);

        // 2: CMD1 with a 48-bit response starting on the 3rd wait period
        clear_counts();
        resp_vec = {88'b0, r_short}; resp_len = 48; resp_delay = 3; resp_arm = 1;
        send_cmd(48'h4100FF8000FF, 1'b1, 1'b0);
        wait_idle("t2_done");
        check_i("t2_valid_cnt", nvalid, 1);
        check_i("t2_timeout_cnt", ntimeout, 0);
        check_v("t2_resp_data", resp_data, {88'b0, r_short});
        check_i("t2_crc_err_cnt", ncrc, 0);
        check_i("t2_valid_at", valid_at_ack, 106);

        // 3: no start bit -> timeout after 64 wait + 8 trailing periods
        clear_counts();
        send_cmd(48'h4D00010000FF, 1'b1, 1'b0);
        wait_idle("t3_done");
        check_i("t3_timeout_cnt", ntimeout, 1);
        check_i("t3_valid_cnt", nvalid, 0);
        check_i("t3_timeout_at", timeout_at_ack, 120);
        check_i("t3_acks", ack_count, 120);
        check_v("t3_resp_hold", resp_data, {88'b0, r_short});

        // 4: 136-bit CID response, tick continuous from wait through receive
        clear_counts();
        resp_vec = r_cid; resp_len = 136; resp_delay = 2; resp_arm = 1;
        mon_end = 48 + 2 + 135; mon_en = 1;
        send_cmd(48'h4200000000FF, 1'b1, 1'b1);
        wait_idle("t4_done");
        check_v("t4_resp_data", resp_data, r_cid);
        check_i("t4_valid_cnt", nvalid, 1);
        check_i("t4_crc_err_cnt", ncrc, 0);
        check_i("t4_tick_gaps", tick_gaps, 0);
        check_i("t4_acks", ack_count, 193);

        // 5: reset during bit 20 of SEND, then a clean command
        clear_counts();
        send_cmd(48'h400000000095, 1'b1, 1'b0);
        n = 0;
        while (ack_count < 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_i("t5_reach_bit20", ack_count, 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_b("t5_async_tick", tick, 1'b0);
        check_b("t5_async_oe", mmc_cmd_oe, 1'b0);
        check_b("t5_async_cmd_o", mmc_cmd_o, 1'b1);
        check_b("t5_async_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_i("t5_no_pulses", nvalid + ntimeout, 0);
        check_b("t5_idle", busy, 1'b0);
        check_v("t5_resp_cleared", resp_data, '0);
        clear_counts();
        send_cmd(48'h400000000095, 1'b0, 1'b0);
        wait_idle("t5_rerun_done");
        check_v("t5_rerun_tx", {88'b0, tx_cap}, {88'b0, 48'h400000000095});
        check_i("t5_rerun_acks", ack_count, 56);

`ifdef MMC_CMD_CRC7_EN
        // 6: generated CRC for CMD0 and a corrupted response CRC
        clear_counts();
        send_cmd(48'h400000000001, 1'b0, 1'b0);
        wait_idle("t6_tx_done");
        check_v("t6_tx_bits", {88'b0, tx_cap}, {88'b0, 48'h400000000095});
        check_v("t6_tx_crc", {129'b0, tx_cap[7:1]}, {129'b0, 7'h4A});
        clear_counts();
        resp_vec = {88'b0, r_short ^ 48'h8}; resp_len = 48; resp_delay = 1; resp_arm = 1;
        send_cmd(48'h4100FF8000FF, 1'b1, 1'b0);
        wait_idle("t6_rx_done");
        check_i("t6_valid_cnt", nvalid, 1);
        check_i("t6_crc_err_cnt", ncrc, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
